rst_seq: RTL and testbench

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_seq_pkg.sv | 22 ++
 rtl/sync_ff.sv | 31 +++
 rtl/rst_seq.sv | 127 ++++++++++++
 tb/tb_rst_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    MEM_INIT  = 3'd2,
    GAP       = 3'd3,
    RUN       = 3'd4
  } state_e;

  localparam int unsigned LOSS_CNT_W = 8;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single-bit signal entering the clk domain.
// Depth and reset value are parameters so it can be reused elsewhere.
module sync_ff #(
  parameter int unsigned DEPTH     = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q << 1;
    stage_d[0] = d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= {DEPTH{RESET_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/rst_seq.sv
// Power-up reset sequencer: waits for a stable PLL lock, releases the memory
// reset, waits for mem_ready, then releases the core reset after a gap.
// Define RST_SEQ_LOSS_CNT_EN to build the saturating lock-loss/timeout counter.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned MEM_TIMEOUT   = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_lock,
  input  logic                  mem_ready,
  output logic                  rst_mem,
  output logic                  rst_core,
  output logic                  running,
  output logic [LOSS_CNT_W-1:0] loss_cnt
);

  localparam int unsigned CNT_MAX = max3(STABLE_CYCLES, GAP_CYCLES, MEM_TIMEOUT);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic lock_s;

  sync_ff #(
    .DEPTH    (2),
    .RESET_VAL(1'b0)
  ) u_lock_sync (
    .clk  (clk),
    .reset(reset),
    .d    (pll_lock),
    .q    (lock_s)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_mem_q, rst_mem_d;
  logic             rst_core_q, rst_core_d;
  logic             running_q, running_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = STABLE;
      end
      STABLE: begin
        if (cnt_q == STABLE_LAST) state_d = MEM_INIT;
      end
      MEM_INIT: begin
        if (mem_ready) state_d = GAP;
        else if (cnt_q == TIMEOUT_LAST) state_d = WAIT_LOCK;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = RUN;
      end
      RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase

    // Lock loss beats every other transition, including a same-cycle timeout.
    if (!lock_s && (state_q != WAIT_LOCK)) state_d = WAIT_LOCK;
    if (state_d != state_q) cnt_d = '0;

    // Outputs are decoded from the next state so they move on the same edge.
    rst_mem_d  = (state_d == WAIT_LOCK) || (state_d == STABLE);
    rst_core_d = (state_d != RUN);
    running_d  = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      rst_mem_q  <= 1'b1;
      rst_core_q <= 1'b1;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_mem_q  <= rst_mem_d;
      rst_core_q <= rst_core_d;
      running_q  <= running_d;
    end
  end

  assign rst_mem  = rst_mem_q;
  assign rst_core = rst_core_q;
  assign running  = running_q;

`ifdef RST_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  loss_evt;

  // Leaving a post-release state for WAIT_LOCK is either lock loss or timeout.
  always_comb begin
    loss_evt = ((state_q == MEM_INIT) || (state_q == GAP) || (state_q == RUN)) &&
               (state_d == WAIT_LOCK);
    loss_d   = loss_q;
    if (loss_evt && (loss_q != '1)) loss_d = loss_q + LOSS_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: reset table, directed sequences and randomized stimulus
// checked against an elapsed-cycle reference model.
module tb_rst_seq;

  localparam int S = 32;
  localparam int G = 4;
  localparam int T = 100;
`ifdef RST_SEQ_LOSS_CNT_EN
  localparam int LOSS_EN = 1;
`else
  localparam int LOSS_EN = 0;
`endif

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       mem_ready;
  logic       rst_mem;
  logic       rst_core;
  logic       running;
  logic [7:0] loss_cnt;

  rst_seq #(
    .STABLE_CYCLES(S),
    .GAP_CYCLES   (G),
    .MEM_TIMEOUT  (T)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pll_lock (pll_lock),
    .mem_ready(mem_ready),
    .rst_mem  (rst_mem),
    .rst_core (rst_core),
    .running  (running),
    .loss_cnt (loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: 'age' is edges elapsed since the sequence left WAIT_LOCK,
  // 'rdy' the age at which mem_ready was accepted (-1 if not yet).
  bit h1 = 0, h2 = 0;
  bit active = 0;
  int age = 0;
  int rdy = -1;
  int exp_loss = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic bump();
    if (LOSS_EN != 0 && exp_loss < 255) exp_loss++;
  endtask

  task automatic model_edge(input bit r, input bit l, input bit m);
    bit ls;
    ls = h2;
    if (r) begin
      h1 = 0; h2 = 0; active = 0; exp_loss = 0;
    end else begin
      h2 = h1; h1 = l;
      if (!active) begin
        if (ls) begin active = 1; age = 0; rdy = -1; end
      end else if (!ls) begin
        if (age >= S) bump();
        active = 0;
      end else begin
        if (age >= S && rdy < 0) begin
          if (m) rdy = age;
          else if (age == S + T - 1) begin bump(); active = 0; end
        end
        age++;
      end
    end
  endtask

  task automatic check_model();
    bit em, er;
    em = !active || (age < S);
    er = active && (rdy >= 0) && (age >= rdy + 1 + G);
    chk("model_rst_mem", rst_mem, em);
    chk("model_rst_core", rst_core, !er);
    chk("model_running", running, er);
    chk("model_loss_cnt", loss_cnt, exp_loss);
    total++;
    if (rst_mem !== 1'b0 && rst_core === 1'b0) begin
      bad++;
      $display("FAIL order: rst_core=%b while rst_mem=%b at %0t", rst_core, rst_mem, $time);
    end
  endtask

  task automatic step(input bit r, input bit l, input bit m);
    reset = r; pll_lock = l; mem_ready = m;
    @(posedge clk);
    model_edge(r, l, m);
    @(negedge clk);
    check_model();
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return rst_mem;
      1:       return rst_core;
      default: return running;
    endcase
  endfunction

  task automatic run_until(input int sel, input logic val, input bit l, input bit m,
                           input int limit, output int n);
    n = 0;
    do begin
      step(0, l, m);
      n++;
    end while (get_sig(sel) !== val && n < limit);
    if (get_sig(sel) !== val) n = -1;
  endtask

  typedef struct {
    bit rst; bit lock; bit ready;
    bit mem; bit core; bit run;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n;
    tbl[0] = '{1, 0, 0, 1, 1, 0};
    tbl[1] = '{1, 1, 1, 1, 1, 0};
    tbl[2] = '{1, 1, 0, 1, 1, 0};
    tbl[3] = '{1, 1, 1, 1, 1, 0};
    tbl[4] = '{0, 1, 1, 1, 1, 0};
    tbl[5] = '{0, 1, 1, 1, 1, 0};
    tbl[6] = '{0, 1, 1, 1, 1, 0};
    tbl[7] = '{0, 0, 1, 1, 1, 0};
    tbl[8] = '{0, 0, 0, 1, 1, 0};
    tbl[9] = '{1, 0, 0, 1, 1, 0};

    reset = 1'b1; pll_lock = 1'b0; mem_ready = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst, tbl[i].lock, tbl[i].ready);
      chk("tbl_rst_mem", rst_mem, tbl[i].mem);
      chk("tbl_rst_core", rst_core, tbl[i].core);
      chk("tbl_running", running, tbl[i].run);
      chk("tbl_loss_cnt", loss_cnt, 0);
    end

    // Lock rise with mem_ready always high.
    for (int i = 0; i < 4; i++) step(1, 0, 1);
    run_until(0, 1'b0, 1, 1, 4 * S, n);
    chk("rise_mem_latency", n, S + 3);
    run_until(1, 1'b0, 1, 1, 4 * G + 10, n);
    chk("rise_core_gap", n, G + 1);
    chk("rise_running", running, 1);

    // One-cycle lock loss while running.
    step(0, 0, 1);
    step(0, 1, 1);
    step(0, 1, 1);
    chk("loss_rst_mem", rst_mem, 1);
    chk("loss_rst_core", rst_core, 1);
    chk("loss_cnt_after_run_loss", loss_cnt, LOSS_EN);
    run_until(2, 1'b1, 1, 1, 4 * S, n);
    chk("loss_rerun_latency", n, S + G + 2);
    chk("loss_cnt_after_rerun", loss_cnt, LOSS_EN);

    // Glitch midway through STABLE restarts the count, no loss recorded.
    for (int i = 0; i < 4; i++) step(1, 0, 1);
    for (int i = 0; i < 18; i++) step(0, 1, 1);
    chk("glitch_pre_rst_mem", rst_mem, 1);
    step(0, 0, 1);
    run_until(0, 1'b0, 1, 1, 4 * S, n);
    chk("glitch_restart_latency", n, S + 3);
    chk("glitch_loss_cnt", loss_cnt, 0);

    // Memory timeout, two attempts.
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    run_until(0, 1'b0, 1, 0, 4 * S, n);
    chk("tmo_first_entry", n, S + 3);
    run_until(0, 1'b1, 1, 0, 2 * T, n);
    chk("tmo_first_wait", n, T);
    chk("tmo_loss_1", loss_cnt, LOSS_EN);
    run_until(0, 1'b0, 1, 0, 4 * S, n);
    chk("tmo_second_entry", n, S + 1);
    run_until(0, 1'b1, 1, 0, 2 * T, n);
    chk("tmo_second_wait", n, T);
    chk("tmo_loss_2", loss_cnt, 2 * LOSS_EN);

    // Reset asserted during GAP.
    run_until(0, 1'b0, 1, 1, 4 * S, n);
    chk("gap_entry_latency", n, S + 1);
    step(0, 1, 1);
    chk("gap_rst_mem", rst_mem, 0);
    chk("gap_rst_core", rst_core, 1);
    step(1, 1, 1);
    chk("midrst_rst_mem", rst_mem, 1);
    chk("midrst_rst_core", rst_core, 1);
    chk("midrst_running", running, 0);
    chk("midrst_loss_cnt", loss_cnt, 0);
    run_until(0, 1'b0, 1, 1, 4 * S, n);
    chk("midrst_restart_latency", n, S + 3);

    // 300 lock losses from MEM_INIT.
    for (int i = 0; i < 2; i++) step(1, 0, 0);
    for (int i = 0; i < 300; i++) begin
      run_until(0, 1'b0, 1, 0, 4 * S, n);
      for (int k = 0; k < 3; k++) step(0, 0, 0);
      if (i == 9) chk("sat_loss_10", loss_cnt, 10 * LOSS_EN);
    end
    chk("sat_loss_final", loss_cnt, 255 * LOSS_EN);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 399) == 0,
           $urandom_range(0, 999) < 995,
           $urandom_range(0, 9) < 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
